byte_lsu: RTL and testbench
===========================

# byte_lsu

- Load/store sequencer between the CPU datapath and the byte-wide data RAM (8-bit data, ADDRESS_WIDTH address, combinational read).
- Accepts one 8/16/32-bit load or store per request.
- Issues the matching one, two or four byte-wide RAM accesses, little-endian, one byte per cycle.
- Returns a single-cycle response pulse with extended load data or an error flag.
- Drives the RAM's wr_en/rd_en/wr_addr/rd_addr/din and consumes its dout.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, byte address width; must match the RAM.
- XLEN, 32, CPU data width; fixed at 32.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  zero-extend a load (LBU/LHU)
- req_addr  in  ADDRESS_WIDTH  base byte address
- req_wdata  in  XLEN  store data, low bytes used
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  request rejected, valid with rsp_valid
- rsp_rdata  out  XLEN  extended load data; holds its value between responses
- mem_wr_en  out  1  RAM write enable
- mem_rd_en  out  1  RAM read enable
- mem_wr_addr  out  ADDRESS_WIDTH  RAM write address
- mem_rd_addr  out  ADDRESS_WIDTH  RAM read address
- mem_din  out  8  RAM write byte
- mem_dout  in  8  RAM read byte, combinational from mem_rd_addr

## Operation
- States:
  - IDLE: req_ready=1.
  - ACCESS: one RAM byte per cycle.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Handshake:
  - A request is accepted when req_valid & req_ready in IDLE.
  - On acceptance, latch addr, we, size, unsigned and wdata; clear byte counter cnt; go to ACCESS.
  - Request inputs are ignored outside IDLE.
- Byte count n: 1, 2 or 4 for sizes 0, 1, 2.
- Size 3 is an error:
  - No RAM access.
  - Go directly IDLE -> RESP with rsp_err=1.
  - rsp_rdata is unchanged.
- ACCESS cycle with index cnt:
  - Byte address = latched addr + cnt, modulo 2^ADDRESS_WIDTH (wraps 0xFF -> 0x00 at default width).
  - Store: mem_wr_en=1, mem_wr_addr = that address, mem_din = wdata[8*cnt +: 8].
  - Load: mem_rd_en=1, mem_rd_addr = that address; mem_dout is captured into a 32-bit assembly register, byte cnt, at the clock edge.
  - The block never asserts mem_wr_en and mem_rd_en in the same cycle.
  - cnt increments each cycle; the ACCESS cycle with cnt = n-1 transitions to RESP.
- Load extension, applied when entering RESP:
  - Byte: bit 7 extends to bit 31 (zeros if unsigned).
  - Half: bit 15 extends to bit 31 (zeros if unsigned).
  - Word: passes through unchanged.
  - rsp_rdata updates on the RESP entry edge.
- Store response: rsp_rdata is driven to 0.
- Idle outputs: when not in ACCESS, all mem_* outputs are 0.
- Reset, including mid-operation:
  - State goes to IDLE immediately, asynchronously.
  - req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* = 0, cnt=0.
  - Bytes already written to the RAM stay written; there is no rollback.

## Timing
- Request accepted at edge T.
- ACCESS cycles T..T+n-1 (edges T+1..T+n).
- rsp_valid is high during cycle T+n.
- req_ready is high again in cycle T+n+1.
- Throughput: one request per n+2 cycles.
- Error request: rsp_valid in cycle T; req_ready in cycle T+1.
- rsp_valid has no backpressure; the consumer must sample it in the pulse cycle.

## Configuration
- Macro BYTE_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is an error.
  - Behaviour is identical to size 3: no RAM access, rsp_err=1, response in the cycle after acceptance.
- Undefined:
  - Misaligned accesses proceed byte-by-byte at addr..addr+n-1 with address wrap.
  - rsp_err is raised only for size 3.

## Structure
- Package lsu_pkg holds:
  - State enum: IDLE, ACCESS, RESP.
  - Size constants: SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2.
  - Function returning n for a size.
  - Function returning the misalign check.
- One sub-module, lsu_load_ext:
  - Combinational sign/zero extension of the 32-bit assembled word by size and unsigned.
  - Instantiated once.

## Test plan
- Word store 0xDEADBEEF at 0x10 -> mem_wr_en for 4 cycles at 0x10..0x13 with din EF, BE, AD, DE; rsp_valid 5 cycles after accept; rsp_err=0.
- Load back at 0x10:
  - Signed byte -> 0xFFFFFFEF.
  - LBU -> 0x000000EF.
  - Signed half -> 0xFFFFBEEF.
  - Word -> 0xDEADBEEF.
- Word store at 0xFE (macro undefined) -> writes 0xFE, 0xFF, 0x00, 0x01; with macro defined -> no mem_wr_en, rsp_err=1 one cycle after accept.
- req_size=3 -> no RAM enable, rsp_err=1, rsp_rdata keeps its previous value.
- rst_n low during cycle 2 of a word store -> outputs reset immediately; only 0x10 and 0x11 modified; req_ready=1 after release.
- req_valid held high continuously -> back-to-back requests accepted only in IDLE; req_ready low throughout ACCESS/RESP; no request dropped or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SIZE_B    = 2'd0;
  localparam logic [1:0] SIZE_H    = 2'd1;
  localparam logic [1:0] SIZE_W    = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Number of RAM byte accesses for a legal size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by access size.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (size)
      SIZE_B:  data = {{24{word[7] & ~is_unsigned}}, word[7:0]};
      SIZE_H:  data = {{16{word[15] & ~is_unsigned}}, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/byte_lsu.sv
// Byte-serial load/store sequencer in front of a byte-wide RAM with combinational read.
// Define BYTE_LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module byte_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [XLEN-1:0]          rsp_rdata,
  output logic                     mem_wr_en,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  output logic [7:0]               mem_din,
  input  logic [7:0]               mem_dout
);

  lsu_state_e               state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic                     we_reg;
  logic [1:0]               size_reg;
  logic                     unsigned_reg;
  logic [XLEN-1:0]          wdata_reg;
  logic [1:0]               cnt_reg;
  logic                     err_reg;
  logic [31:0]              asm_reg;
  logic [XLEN-1:0]          rdata_reg;

  logic                     accept;
  logic                     req_err;
  logic                     last_byte;
  logic [ADDRESS_WIDTH-1:0] byte_addr;
  logic [31:0]              asm_next;
  logic [31:0]              ext_data;

`ifdef BYTE_LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == SIZE_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
  assign req_err = (req_size == SIZE_RSVD);
`endif

  assign accept    = (state_reg == IDLE) && req_valid;
  assign last_byte = ({1'b0, cnt_reg} == (size_bytes(size_reg) - 3'd1));
  assign byte_addr = addr_reg + ADDRESS_WIDTH'(cnt_reg);

  // Merge the byte arriving this cycle so the final byte is visible to the extender.
  always_comb begin
    asm_next = asm_reg;
    asm_next[{cnt_reg, 3'b000} +: 8] = mem_dout;
  end

  lsu_load_ext u_load_ext (
    .word        (asm_next),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .data        (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (last_byte) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      size_reg     <= SIZE_B;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      cnt_reg      <= 2'd0;
      err_reg      <= 1'b0;
      asm_reg      <= '0;
      rdata_reg    <= '0;
    end else if (accept) begin
      addr_reg     <= req_addr;
      we_reg       <= req_we;
      size_reg     <= req_size;
      unsigned_reg <= req_unsigned;
      wdata_reg    <= req_wdata;
      cnt_reg      <= 2'd0;
      err_reg      <= req_err;
      asm_reg      <= '0;
    end else if (state_reg == ACCESS) begin
      cnt_reg <= cnt_reg + 2'd1;
      if (!we_reg) begin
        asm_reg <= asm_next;
      end
      if (last_byte) begin
        rdata_reg <= we_reg ? '0 : ext_data;
      end
    end
  end

  always_comb begin
    req_ready   = (state_reg == IDLE);
    rsp_valid   = (state_reg == RESP);
    rsp_err     = (state_reg == RESP) && err_reg;
    rsp_rdata   = rdata_reg;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    mem_din     = 8'h00;
    if (state_reg == ACCESS) begin
      if (we_reg) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = byte_addr;
        mem_din     = wdata_reg[{cnt_reg, 3'b000} +: 8];
      end else begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = byte_addr;
      end
    end
  end

endmodule

// File: tb/tb_byte_lsu.sv
// Bench for byte_lsu: cycle-level expectation queue built from request semantics, plus literal checks.
module tb_byte_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_wr_addr;
  logic [7:0]  mem_rd_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  byte_lsu #(.ADDRESS_WIDTH(8), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_rd_addr  (mem_rd_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM attached to the DUT
  logic [7:0] ram [256];
  logic       ram_clear = 1'b1;
  assign mem_dout = ram[mem_rd_addr];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_wr_en) begin
      ram[mem_wr_addr] <= mem_din;
    end
  end

  // Expected behaviour of one cycle
  typedef struct packed {
    bit        ready;
    bit        rv;
    bit        re;
    bit        rd_en;
    bit        wr_en;
    bit        upd;
    bit [7:0]  rd_addr;
    bit [7:0]  wr_addr;
    bit [7:0]  din;
    bit [31:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur = '0;
  bit  [7:0]  ref_mem [256];
  bit  [31:0] model_rdata = 32'h0;
  int         checks = 0;
  int         errors = 0;
  int         accepts = 0;
  int         rsp_count = 0;
  bit         last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: on acceptance, expand the request into its expected cycles.
  task automatic model_step();
    exp_t      e;
    int        n;
    bit        err;
    bit [31:0] v;
    bit [7:0]  a;
    if (ram_clear) for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    if (!rst_n) begin
      exp_q.delete();
      return;
    end
    if (cur.wr_en) ref_mem[cur.wr_addr] = cur.din;
    if (!(cur.ready && req_valid)) return;
    accepts++;
    n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    err = (req_size == 2'd3);
`ifdef BYTE_LSU_MISALIGN_TRAP_EN
    if (req_size == 2'd1 && req_addr[0]) err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00) err = 1'b1;
`endif
    if (err) begin
      e = '0;
      e.rv = 1'b1;
      e.re = 1'b1;
      exp_q.push_back(e);
      return;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      e = '0;
      a = req_addr + 8'(i);
      if (req_we) begin
        e.wr_en   = 1'b1;
        e.wr_addr = a;
        e.din     = 8'(req_wdata >> (8 * i));
      end else begin
        e.rd_en   = 1'b1;
        e.rd_addr = a;
        v = v + (32'(ref_mem[a]) << (8 * i));
      end
      exp_q.push_back(e);
    end
    if (!req_we && !req_unsigned) begin
      if (n == 1 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
      if (n == 2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    e = '0;
    e.rv    = 1'b1;
    e.upd   = 1'b1;
    e.rdata = req_we ? 32'h0 : v;
    exp_q.push_back(e);
  endtask

  task automatic compare_step();
    if (!rst_n) begin
      exp_q.delete();
      cur = '0;
      cur.ready = 1'b1;
      model_rdata = 32'h0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
      cur.ready = 1'b1;
    end
    if (cur.rv && cur.upd) model_rdata = cur.rdata;
    chk("req_ready",   32'(req_ready),   32'(cur.ready));
    chk("rsp_valid",   32'(rsp_valid),   32'(cur.rv));
    chk("rsp_err",     32'(rsp_err),     32'(cur.re));
    chk("rsp_rdata",   rsp_rdata,        model_rdata);
    chk("mem_wr_en",   32'(mem_wr_en),   32'(cur.wr_en));
    chk("mem_rd_en",   32'(mem_rd_en),   32'(cur.rd_en));
    chk("mem_wr_addr", 32'(mem_wr_addr), 32'(cur.wr_addr));
    chk("mem_rd_addr", 32'(mem_rd_addr), 32'(cur.rd_addr));
    chk("mem_din",     32'(mem_din),     32'(cur.din));
    if (rsp_valid) begin
      rsp_count++;
      last_err = rsp_err;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_step();
  end

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (cur.ready) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: still busy after 30 cycles, expected idle", tag);
  endtask

  task automatic issue(input bit we, input bit [1:0] size, input bit uns,
                       input bit [7:0] addr, input bit [31:0] wdata, input string tag);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle(tag);
    $display("txn %s: we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             tag, we, size, uns, addr, wdata, rsp_rdata, last_err);
  endtask

  int a0;
  int r0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
    ram_clear = 1'b0;
    #1 rst_n = 1'b1;
    wait_idle("init");

    issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, "sw_0x10");
    chk("sw_ram10", 32'(ram[8'h10]), 32'hEF);
    chk("sw_ram11", 32'(ram[8'h11]), 32'hBE);
    chk("sw_ram12", 32'(ram[8'h12]), 32'hAD);
    chk("sw_ram13", 32'(ram[8'h13]), 32'hDE);
    chk("sw_err", 32'(last_err), 32'd0);

    issue(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, "lb");
    chk("lb_data", rsp_rdata, 32'hFFFFFFEF);
    issue(1'b0, 2'd0, 1'b1, 8'h10, 32'h0, "lbu");
    chk("lbu_data", rsp_rdata, 32'h000000EF);
    issue(1'b0, 2'd1, 1'b0, 8'h10, 32'h0, "lh");
    chk("lh_data", rsp_rdata, 32'hFFFFBEEF);
    issue(1'b0, 2'd1, 1'b1, 8'h10, 32'h0, "lhu");
    chk("lhu_data", rsp_rdata, 32'h0000BEEF);
    issue(1'b0, 2'd1, 1'b0, 8'h11, 32'h0, "lh_odd");
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "lw");
    chk("lw_data", rsp_rdata, 32'hDEADBEEF);

    issue(1'b1, 2'd3, 1'b0, 8'h20, 32'h12345678, "size3");
    chk("size3_err", 32'(last_err), 32'd1);
    chk("size3_rdata_kept", rsp_rdata, 32'hDEADBEEF);
    chk("size3_ram20", 32'(ram[8'h20]), 32'h00);

    issue(1'b1, 2'd2, 1'b0, 8'hFE, 32'h11223344, "sw_0xfe");
`ifdef BYTE_LSU_MISALIGN_TRAP_EN
    chk("mis_err", 32'(last_err), 32'd1);
    chk("mis_ramfe", 32'(ram[8'hFE]), 32'h00);
    chk("mis_ram00", 32'(ram[8'h00]), 32'h00);
`else
    chk("wrap_err", 32'(last_err), 32'd0);
    chk("wrap_ramfe", 32'(ram[8'hFE]), 32'h44);
    chk("wrap_ramff", 32'(ram[8'hFF]), 32'h33);
    chk("wrap_ram00", 32'(ram[8'h00]), 32'h22);
    chk("wrap_ram01", 32'(ram[8'h01]), 32'h11);
`endif

    // Reset during the third byte of a word store.
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "lw_pre_reset");
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 8'h10; req_wdata = 32'h55667788; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", 32'(req_ready), 32'd1);
    chk("rst_async_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_async_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_idle("post_reset");
    chk("rst_ram10", 32'(ram[8'h10]), 32'h88);
    chk("rst_ram11", 32'(ram[8'h11]), 32'h77);
    chk("rst_ram12", 32'(ram[8'h12]), 32'hAD);
    chk("rst_ram13", 32'(ram[8'h13]), 32'hDE);
    chk("rst_ready_after", 32'(req_ready), 32'd1);
    $display("txn reset_mid_store: ram[10..13]=%h %h %h %h", ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);

    // req_valid held high for 13 edges of byte loads: accepts at edges 0,3,6,9,12.
    a0 = accepts;
    r0 = rsp_count;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 8'h10; req_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      #1 req_addr = req_addr + 8'd1;
    end
    req_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_accepts", 32'(accepts - a0), 32'd5);
    chk("b2b_responses", 32'(rsp_count - r0), 32'd5);
    $display("txn b2b: accepts=%0d responses=%0d last_rdata=%h", accepts - a0, rsp_count - r0, rsp_rdata);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
